unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (fetch) and the MEM stage (load/store).
//  Runs a one-outstanding-transaction FSM and issues registered requests to memory.
//  Drives if_stall / mem_stall, which the pipeline ORs into its global stall and flush_id_ex.
//  Sits between the pipeline stages and the memory model or bus.
// PARAMETERS
//  ADDR_W  32  byte address width
//  DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//  clk        in   1         clock; all state changes on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  if_req     in   1         fetch request; held until if_valid
//  if_addr    in   ADDR_W    fetch address
//  if_kill    in   1         branch redirect; discard the in-flight or granted fetch
//  if_rdata   out  DATA_W    fetched instruction; valid while if_valid is high
//  if_valid   out  1         one-cycle pulse, fetch complete
//  d_req      in   1         load/store request; held until d_valid
//  d_we       in   1         1 = store
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_wstrb    in   DATA_W/8  store byte enables
//  d_rdata    out  DATA_W    load data; valid while d_valid is high
//  d_valid    out  1         one-cycle pulse, data access complete
//  mem_req    out  1         request to memory; held high until mem_ready
//  mem_we     out  1         request is a write
//  mem_addr   out  ADDR_W    latched address
//  mem_wdata  out  DATA_W    latched write data
//  mem_wstrb  out  DATA_W/8  latched byte enables
//  mem_rdata  in   DATA_W    read data; valid while mem_ready is high
//  mem_ready  in   1         transaction complete; sampled only while mem_req is high
//  if_stall   out  1         comb: if_req & ~if_valid
//  mem_stall  out  1         comb: d_req & ~d_valid
//  perf_if_wait  out  32     cycles with if_stall high (see CONFIGURATION)
//  perf_d_wait   out  32     cycles with mem_stall high (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state=IDLE, last_grant=FETCH, kill_pend=0; every registered output is 0.
//  States: IDLE, FETCH, DATA.
//  IDLE grant rules:
//   - d_req only -> DATA.
//   - if_req & ~if_kill only -> FETCH.
//   - Both requested -> DATA, unless last_grant==DATA, then FETCH (alternation, no starvation).
//   - No request, or a fetch-only request killed by if_kill -> stay in IDLE.
//   - On grant: latch addr/we/wdata/wstrb into the mem_* registers, set mem_req=1, update last_grant.
//   - Stores drive mem_we=1. Fetches drive mem_we=0 and mem_wstrb=0.
//  FETCH or DATA state:
//   - Hold mem_req and all mem_* outputs stable until mem_ready.
//   - On mem_ready: mem_req=0, go to IDLE.
//   - DATA completion: pulse d_valid next cycle. For a load, d_rdata=mem_rdata. For a store, d_rdata holds its old value.
//   - FETCH completion: pulse if_valid with if_rdata=mem_rdata, unless kill_pend or if_kill is set this cycle; then drop the response.
//  if_kill in FETCH sets kill_pend. kill_pend clears when the fetch completes.
//  Latency: request seen in IDLE at cycle N -> mem_req high at N+1 -> mem_ready at cycle M >= N+1 -> valid at M+1.
//   Minimum is 2 cycles.
//  Valid cycle: the matching stall output is low, so the pipeline advances.
//   A request still high the cycle after valid is a new request.
//  If mem_ready arrives while mem_req is low, ignore it.
//  Async reset mid-transaction drops it: mem_req falls immediately and state returns to IDLE.
//   The memory is reset together with this block.
//  Address/data wrap: none. Addresses pass through unchanged.
// CONFIGURATION
//  Macro ARB_PERF_CNT_EN.
//  Defined:
//   - perf_if_wait / perf_d_wait count cycles in which if_stall / mem_stall is high.
//   - Counters saturate at 32'hFFFF_FFFF. They reset to 0 on rst_n.
//  Undefined: both ports are tied to 32'h0 and no counter flops are built.
// STRUCTURE
//  Package mem_arb_pkg holds:
//   - arb_state_t enum {IDLE, FETCH, DATA}
//   - grant_t enum {GNT_FETCH, GNT_DATA}
//   - localparams for default ADDR_W and DATA_W
//  Sub-module mem_arb_perf_cnt: one saturating 32-bit counter with clk, rst_n, inc, count.
//   Instantiated twice, only under ARB_PERF_CNT_EN.
// TESTING
//  1. Fetch only: if_req, if_addr=0x100; mem_ready 3 cycles after mem_req, mem_rdata=0x00500093
//     -> mem_addr=0x100, mem_we=0; if_valid pulses once with if_rdata=0x00500093;
//        if_stall is high for 4 cycles, then low.
//  2. Both requested at once, last_grant=FETCH -> DATA granted first.
//     After d_valid, if d_req is high again -> FETCH is granted next (alternation).
//  3. Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011
//     -> mem_we=1 and all mem_* fields match; d_valid pulses; d_rdata is unchanged.
//  4. if_kill one cycle after the fetch grant; mem_ready arrives later
//     -> no if_valid pulse; FSM returns to IDLE; the next fetch completes normally.
//  5. rst_n driven low while in DATA with mem_req high
//     -> mem_req=0 and state=IDLE in the same cycle, with no clock edge needed; no d_valid pulse.
//  6. With ARB_PERF_CNT_EN: 5-cycle data stall -> perf_d_wait=5.
//     Without the macro -> perf_d_wait stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Purpose: saturating 32-bit event counter for arbiter stall statistics.
// Latency: count reflects inc one cycle later.
// Backpressure: none; holds at 32'hFFFF_FFFF once saturated.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'h0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported memory between fetch and load/store; stall counters under ARB_PERF_CNT_EN.
// Latency: request in IDLE at N -> mem_req at N+1 -> mem_ready at M -> valid pulse at M+1 (2 cycles minimum).
// Backpressure: one outstanding transaction; mem_* held stable until mem_ready, requesters stalled until valid.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_kill,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  if_stall,
    output logic                  mem_stall,
    output logic [31:0]           perf_if_wait,
    output logic [31:0]           perf_d_wait
);

    arb_state_t state;
    grant_t     last_grant;
    logic       kill_pend;

    logic d_pend;
    logic f_pend;
    logic pick_data;
    logic pick_fetch;
    logic mem_done;

    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = d_req & ~d_valid;

    // A request seen during its own valid cycle is the one just completed, not a new one.
    assign d_pend     = d_req & ~d_valid;
    assign f_pend     = if_req & ~if_valid & ~if_kill;
    assign pick_data  = d_pend & (~f_pend | (last_grant == GNT_FETCH));
    assign pick_fetch = f_pend & ~pick_data;
    assign mem_done   = mem_req & mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GNT_FETCH;
            kill_pend  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        state      <= DATA;
                        last_grant <= GNT_DATA;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_wstrb  <= d_wstrb;
                    end else if (pick_fetch) begin
                        state      <= FETCH;
                        last_grant <= GNT_FETCH;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                    end
                end
                FETCH: begin
                    if (if_kill) begin
                        kill_pend <= 1'b1;
                    end
                    if (mem_done) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        kill_pend <= 1'b0;
                        if (!kill_pend && !if_kill) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DATA: begin
                    if (mem_done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    mem_arb_perf_cnt u_perf_if (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_stall),
        .count (perf_if_wait)
    );

    mem_arb_perf_cnt u_perf_d (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_stall),
        .count (perf_d_wait)
    );
`else
    assign perf_if_wait = 32'h0;
    assign perf_d_wait  = 32'h0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        if_stall;
    logic        mem_stall;
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_wait;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_kill      (if_kill),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wstrb      (d_wstrb),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .if_stall     (if_stall),
        .mem_stall    (mem_stall),
        .perf_if_wait (perf_if_wait),
        .perf_d_wait  (perf_d_wait)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %h expected 0", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h expected 0", mem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got %h expected 0", if_valid); end
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid got %h expected 0", d_valid); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got %h expected 0", d_rdata); end
        n_checks++; if (perf_d_wait !== 32'h0) begin n_fail++; $display("FAIL rst_perf_d got %h expected 0", perf_d_wait); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_state got %0d expected %0d", dut.state, IDLE); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        int stalls = 0;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); stalls += int'(if_stall);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL f1_req_c0 got %h expected 0", mem_req); end
        next_cycle();
        @(negedge clk); stalls += int'(if_stall);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL f1_req_c1 got %h expected 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL f1_addr got %h expected 100", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL f1_we got %h expected 0", mem_we); end
        n_checks++; if (mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL f1_wstrb got %h expected 0", mem_wstrb); end
        next_cycle();
        @(negedge clk); stalls += int'(if_stall);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL f1_early_valid got %h expected 0", if_valid); end
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk); stalls += int'(if_stall);
        next_cycle();
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk); stalls += int'(if_stall);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL f1_valid got %h expected 1", if_valid); end
        n_checks++; if (if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL f1_rdata got %h expected 00500093", if_rdata); end
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL f1_stall_low got %h expected 0", if_stall); end
        n_checks++; if (stalls !== 4) begin n_fail++; $display("FAIL f1_stall_cycles got %0d expected 4", stalls); end
        if_req = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL f1_single_pulse got %h expected 0", if_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL f1_no_regrant got %h expected 0", mem_req); end
        next_cycle();
    endtask

    task automatic test_alternation();
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        @(negedge clk);
        n_checks++; if ({if_stall, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL alt_stalls got %b expected 11", {if_stall, mem_stall}); end
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h3000) begin n_fail++; $display("FAIL alt_data_first got %h expected 3000", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL alt_load_we got %h expected 0", mem_we); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL alt_d_valid got %h expected 1", d_valid); end
        n_checks++; if (d_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL alt_d_rdata got %h expected 11112222", d_rdata); end
        n_checks++; if ({if_stall, mem_stall} !== 2'b10) begin n_fail++; $display("FAIL alt_valid_stalls got %b expected 10", {if_stall, mem_stall}); end
        d_addr = 32'h3004;
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h00A0_0113;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL alt_fetch_next got %h expected 200", mem_addr); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL alt_fetch_req got %h expected 1", mem_req); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL alt_if_valid got %h expected 1", if_valid); end
        n_checks++; if (if_rdata !== 32'h00A0_0113) begin n_fail++; $display("FAIL alt_if_rdata got %h expected 00a00113", if_rdata); end
        if_req = 1'b0;
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h3004) begin n_fail++; $display("FAIL alt_data_again got %h expected 3004", mem_addr); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (d_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL alt_d_rdata2 got %h expected 33334444", d_rdata); end
        d_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        next_cycle();
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL st_we got %h expected 1", mem_we); end
        n_checks++; if (mem_addr !== 32'h2004) begin n_fail++; $display("FAIL st_addr got %h expected 2004", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_wdata got %h expected deadbeef", mem_wdata); end
        n_checks++; if (mem_wstrb !== 4'b0011) begin n_fail++; $display("FAIL st_wstrb got %h expected 3", mem_wstrb); end
        next_cycle();
        d_wdata = 32'h0; d_addr = 32'h0;
        @(negedge clk);
        n_checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h2004, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL st_hold got %h/%h/%h expected 1/2004/deadbeef", mem_req, mem_addr, mem_wdata); end
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'hBADB_AD00;
        @(negedge clk);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL st_d_valid got %h expected 1", d_valid); end
        n_checks++; if (d_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL st_rdata_kept got %h expected 33334444", d_rdata); end
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0;
        next_cycle();
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL st_single_pulse got %h expected 0", d_valid); end
        next_cycle();
    endtask

    task automatic test_kill();
        if_req = 1'b1; if_addr = 32'h400;
        next_cycle();
        if_kill = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h400) begin n_fail++; $display("FAIL kill_first_addr got %h expected 400", mem_addr); end
        next_cycle();
        if_kill = 1'b0;
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL kill_dropped got %h expected 0", if_valid); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL kill_idle got %0d expected %0d", dut.state, IDLE); end
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h500) begin n_fail++; $display("FAIL kill_refetch got %h expected 500", mem_addr); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({if_valid, if_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL kill_next_ok got %h/%h expected 1/12345678", if_valid, if_rdata); end
        if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
        next_cycle();
        @(negedge clk);
        n_checks++; if (dut.state !== DATA) begin n_fail++; $display("FAIL ar_in_data got %0d expected %0d", dut.state, DATA); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req_drop got %h expected 0", mem_req); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL ar_state got %0d expected %0d", dut.state, IDLE); end
        d_req = 1'b0;
        next_cycle();
        rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({d_valid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ar_quiet1 got %b expected 00", {d_valid, mem_req}); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({d_valid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ar_quiet2 got %b expected 00", {d_valid, mem_req}); end
        next_cycle();
    endtask

    task automatic test_perf();
        logic [31:0] exp_d;
`ifdef ARB_PERF_CNT_EN
        exp_d = 32'd5;
`else
        exp_d = 32'd0;
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7000;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h5555_6666;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL perf_d_valid got %h expected 1", d_valid); end
        d_req = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++; if (perf_d_wait !== exp_d) begin n_fail++; $display("FAIL perf_d_wait got %0d expected %0d", perf_d_wait, exp_d); end
        n_checks++; if (perf_if_wait !== 32'd0) begin n_fail++; $display("FAIL perf_if_wait got %0d expected 0", perf_if_wait); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_alternation();
        test_store();
        test_kill();
        test_async_reset();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
